// File: rtl/exe_stage_if.sv
// ID/EXE inputs and EXE/MEM outputs of the execute stage, bundled as one port.
// The slave side is the execute stage; the master side is the surrounding pipeline.
interface exe_stage_if;
    logic [3:0]  control_exe_in;
    logic [2:0]  control_mem_in;
    logic [1:0]  control_wb_in;
    logic [5:0]  alu_op_in;
    logic [7:0]  pc_in;
    logic [31:0] read_data_1_in;
    logic [31:0] read_data_2_in;
    logic [31:0] sign_extend_in;
    logic [4:0]  rt_in;
    logic [4:0]  rd_in;

    logic [31:0] alu_result_out;
    logic [31:0] write_data_out;
    logic [4:0]  write_reg_out;
    logic        zero_out;
    logic [2:0]  control_mem_out;
    logic [1:0]  control_wb_out;
    logic [7:0]  pc_out;
    logic        stall_out;

    modport slave (
        input  control_exe_in, control_mem_in, control_wb_in, alu_op_in, pc_in,
               read_data_1_in, read_data_2_in, sign_extend_in, rt_in, rd_in,
        output alu_result_out, write_data_out, write_reg_out, zero_out,
               control_mem_out, control_wb_out, pc_out, stall_out
    );

    modport master (
        output control_exe_in, control_mem_in, control_wb_in, alu_op_in, pc_in,
               read_data_1_in, read_data_2_in, sign_extend_in, rt_in, rd_in,
        input  alu_result_out, write_data_out, write_reg_out, zero_out,
               control_mem_out, control_wb_out, pc_out, stall_out
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: ALU, iterative shift-add multiplier into HI/LO, and the
// EXE/MEM pipeline register. Stalls upstream while the multiplier is busy.
module exe_stage #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input logic        CLK,
    input logic        RST_N,
    exe_stage_if.slave bus
);
    localparam logic [5:0] OP_SLL   = 6'h00;
    localparam logic [5:0] OP_SRL   = 6'h02;
    localparam logic [5:0] OP_SRA   = 6'h03;
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_ADD   = 6'h20;
    localparam logic [5:0] OP_ADDU  = 6'h21;
    localparam logic [5:0] OP_SUB   = 6'h22;
    localparam logic [5:0] OP_SUBU  = 6'h23;
    localparam logic [5:0] OP_AND   = 6'h24;
    localparam logic [5:0] OP_OR    = 6'h25;
    localparam logic [5:0] OP_XOR   = 6'h26;
    localparam logic [5:0] OP_NOR   = 6'h27;
    localparam logic [5:0] OP_SLT   = 6'h2A;
    localparam logic [5:0] OP_SLTU  = 6'h2B;

    typedef enum logic {IDLE, BUSY} mul_state_t;

    mul_state_t  state, state_nxt;
    logic [31:0] hi, lo;
    logic [63:0] mcand, acc;
    logic [31:0] mplier;
    logic        neg;
    logic [4:0]  count;

    logic [31:0] alu_result_q, write_data_q;
    logic [4:0]  write_reg_q;
    logic        zero_q;
    logic [2:0]  control_mem_q;
    logic [1:0]  control_wb_q;
    logic [7:0]  pc_q;

    logic [31:0] op_a, op_b, alu_res, a_mag, b_mag;
    logic [4:0]  shamt;
    logic        is_mul, is_signed_mul, start, done;
    logic [63:0] acc_sum, product;
    logic        unused_ok;

    assign unused_ok = &{1'b0, bus.control_exe_in[3:2]};

    always_comb begin
        op_a    = bus.read_data_1_in;
        op_b    = bus.control_exe_in[0] ? bus.sign_extend_in : bus.read_data_2_in;
        shamt   = bus.sign_extend_in[10:6];
        alu_res = '0;
        case (bus.alu_op_in)
            OP_ADD, OP_ADDU: alu_res = op_a + op_b;
            OP_SUB, OP_SUBU: alu_res = op_a - op_b;
            OP_AND:          alu_res = op_a & op_b;
            OP_OR:           alu_res = op_a | op_b;
            OP_XOR:          alu_res = op_a ^ op_b;
            OP_NOR:          alu_res = ~(op_a | op_b);
            OP_SLT:          alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SLTU:         alu_res = {31'b0, op_a < op_b};
            OP_SLL:          alu_res = bus.read_data_2_in << shamt;
            OP_SRL:          alu_res = bus.read_data_2_in >> shamt;
            OP_SRA:          alu_res = $unsigned($signed(bus.read_data_2_in) >>> shamt);
            OP_MFHI:         alu_res = hi;
            OP_MFLO:         alu_res = lo;
            default:         alu_res = '0;
        endcase
    end

    // Magnitudes are taken as 32-bit unsigned, so |0x80000000| = 2^31 stays exact.
    always_comb begin
        is_mul        = (bus.alu_op_in == OP_MULT) || (bus.alu_op_in == OP_MULTU);
        is_signed_mul = (bus.alu_op_in == OP_MULT);
        a_mag = (is_signed_mul && op_a[31]) ? (~op_a + 32'd1) : op_a;
        b_mag = (is_signed_mul && op_b[31]) ? (~op_b + 32'd1) : op_b;
        acc_sum = acc + (mplier[0] ? mcand : '0);
        product = neg ? (~acc_sum + 64'd1) : acc_sum;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    state_nxt = BUSY;
                    start     = 1'b1;
                end
            end
            BUSY: begin
                if (count == 5'(MUL_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            count  <= '0;
        end else if (start) begin
            mcand  <= {32'b0, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= is_signed_mul & (op_a[31] ^ op_b[31]);
            count  <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (done) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end
        end
    end

    // While busy the register carries a bubble; non-control fields just hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_result_q  <= '0;
            write_data_q  <= '0;
            write_reg_q   <= '0;
            zero_q        <= 1'b0;
            control_mem_q <= '0;
            control_wb_q  <= '0;
            pc_q          <= '0;
        end else if (state == BUSY) begin
            alu_result_q  <= '0;
            zero_q        <= 1'b1;
            control_mem_q <= '0;
            control_wb_q  <= '0;
        end else begin
            alu_result_q  <= alu_res;
            write_data_q  <= bus.read_data_2_in;
            write_reg_q   <= bus.control_exe_in[1] ? bus.rd_in : bus.rt_in;
            zero_q        <= (alu_res == '0);
            control_mem_q <= is_mul ? 3'b000 : bus.control_mem_in;
            control_wb_q  <= is_mul ? 2'b00 : bus.control_wb_in;
            pc_q          <= bus.pc_in;
        end
    end

    assign bus.alu_result_out  = alu_result_q;
    assign bus.write_data_out  = write_data_q;
    assign bus.write_reg_out   = write_reg_q;
    assign bus.zero_out        = zero_q;
    assign bus.control_mem_out = control_mem_q;
    assign bus.control_wb_out  = control_wb_q;
    assign bus.pc_out          = pc_q;
    assign bus.stall_out       = (state == BUSY);
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipeline. Sits between the ID/EXE pipeline register and the MEM stage. Consumes that register's outputs, performs the ALU operation selected by the 6-bit funct-style opcode, and runs an iterative 32-cycle multiplier into HI/LO. Registers the results into the EXE/MEM boundary and raises a stall request while a multiply is in progress.

## Interface
Parameters:
- `MUL_CYCLES`, default 32: iterations of the shift-add multiplier. Fixed at 32 for this design; any other value is unsupported.

Ports:
- `CLK`  in  1: pipeline clock. All state updates on posedge.
- `RST_N`  in  1: reset, asynchronous, active-low.
- `control_exe_in`  in  4: bit0 `alu_src` (1 = `sign_extend_in` is operand B). bit1 `reg_dst` (1 = rd, 0 = rt). bits3:2 ignored.
- `control_mem_in`  in  3: passed through.
- `control_wb_in`  in  2: passed through. bit0 = reg_write.
- `alu_op_in`  in  6: operation code.
- `pc_in`  in  8: passed through.
- `read_data_1_in`  in  32: operand A.
- `read_data_2_in`  in  32: operand B, and store data.
- `sign_extend_in`  in  32: immediate. Bits 10:6 are the shift amount (shamt).
- `rt_in`, `rd_in`  in  5 each: destination register candidates.
- `alu_result_out`  out  32: registered ALU result.
- `write_data_out`  out  32: registered `read_data_2_in`.
- `write_reg_out`  out  5: registered destination (rd or rt).
- `zero_out`  out  1: registered (result == 0).
- `control_mem_out`  out  3: registered pass-through.
- `control_wb_out`  out  2: registered pass-through.
- `pc_out`  out  8: registered pass-through.
- `stall_out`  out  1: combinational; high while the multiplier is BUSY.

## Operation
- Operand B = `alu_src` ? `sign_extend_in` : `read_data_2_in`.
- Opcodes (hex): 
  - 20/21 add: A+B, wrapping, no overflow trap.
  - 22/23 sub: A−B, wrapping.
  - 24 and, 25 or, 26 xor, 27 nor.
  - 2A slt: signed compare, result 1/0.
  - 2B sltu: unsigned compare, result 1/0.
  - 00 sll and 02 srl: shift `read_data_2_in` by shamt; srl is logical.
  - 03 sra: arithmetic shift right.
  - 10 mfhi: result = HI. 12 mflo: result = LO.
  - 18 mult (signed), 19 multu: start the multiplier.
  - Any other code: result 0.
- `write_reg_out` = `reg_dst` ? rd : rt.
- Multiplier FSM has two states, IDLE and BUSY:
  - IDLE→BUSY on a posedge with opcode 18/19 while IDLE. On entry, latch |A| and |B| (raw values for multu), record the result sign (A[31]^B[31], mult only), clear the 64-bit accumulator, count=0.
  - In BUSY, each posedge: if multiplier bit0 = 1, add the multiplicand into the accumulator; shift; count+1.
  - On the posedge where count==31: commit {HI,LO} = product, negated if the recorded sign is 1; go to IDLE.
  - A 64-bit two's-complement product is required for all inputs, including 0x80000000 operands.
- The mult/multu instruction itself is registered as a bubble: `control_wb_out`=0, `control_mem_out`=0. Its other outputs are don't-care.
- While BUSY, every posedge registers a bubble: `control_wb_out`=0, `control_mem_out`=0, `alu_result_out`=0. Inputs are ignored; the upstream hazard logic holds them.
- A mult/multu presented while BUSY cannot occur, because stall holds it upstream. If it does occur, it is ignored.

## Timing
- Latency 1 cycle: inputs valid before posedge N appear on the outputs after posedge N.
- Multiply sequence:
  - Captured at posedge N; `stall_out` goes high right after posedge N.
  - HI/LO commit at posedge N+32; `stall_out` drops after posedge N+32.
  - An mfhi/mflo presented at posedge N+33 reads the new value.
- mfhi/mflo in the same cycle as the commit edge is impossible, because stall is still high.
- Reset (asynchronous, immediate):
  - All outputs go to 0, including `stall_out`.
  - HI=LO=0; FSM to IDLE; count=0.
  - Reset mid-multiply aborts the operation; HI/LO stay 0 after release.
- The first posedge after `RST_N` rises operates normally.

## Test plan
- add: A=0x7FFFFFFF, B=1, op 20, `reg_dst`=1, rd=5 → `alu_result_out`=0x80000000, `write_reg_out`=5, `zero_out`=0, one cycle later.
- slt vs sltu: A=0xFFFFFFFF, B=1 → op 2A gives 1; op 2B gives 0. Sub with A=B=9 → result 0, `zero_out`=1.
- Immediate and shifts:
  - `alu_src`=1, imm=0xFFFFFFFC, A=10, op 20 → result 6.
  - `read_data_2_in`=0x80000001, shamt=4: op 00 → 0x00000010; op 02 → 0x08000000; op 03 → 0xF8000000.
- Signed multiply: mult A=−3, B=5 → `stall_out` high exactly 32 cycles with bubble outputs; then mflo → 0xFFFFFFF1 and mfhi → 0xFFFFFFFF.
- Unsigned multiply: multu A=0xFFFFFFFF, B=2 → mfhi=1, mflo=0xFFFFFFFE.
- Reset mid-multiply: assert `RST_N`=0 at iteration 10 → all outputs and `stall_out` are 0 immediately; after release, mfhi and mflo both return 0.
